// File: rtl/cnn_mac_acc_27s_15.sv
// Multiply-accumulate window for a CNN layer: sums NUM_TERMS signed
// 11s x 15s products onto a pre-shifted bias, then rounds half up, drops
// SHIFT fraction bits, optionally applies ReLU, and saturates the result
// to a 15-bit ap_fixed<15,6> output held under a valid/ready handshake.
module cnn_mac_acc_27s_15 #(
  parameter int NUM_TERMS = 25,
  parameter int SHIFT     = 9,
  parameter int ACC_WIDTH = 34,
  parameter int RELU      = 0
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic signed [26:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic signed [14:0] bias,
  output logic signed [14:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_sat
);

  localparam int CNT_W   = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);
  localparam int RND_RAW = ACC_WIDTH + 1 - SHIFT;
  // The rounded value is kept at least 16 bits wide so the clip bounds
  // always fit, whatever SHIFT is chosen.
  localparam int RND_W   = (RND_RAW > 16) ? RND_RAW : 16;
  localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(1) <<< (SHIFT - 1);
  localparam logic signed [RND_W-1:0]   MAXV = RND_W'(16383);
  localparam logic signed [RND_W-1:0]   MINV = RND_W'(-16384);

  typedef enum logic [1:0] {
    ACC = 2'd0,
    SAT = 2'd1,
    OUT = 2'd2
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [CNT_W-1:0]            count;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] din_ext;
  logic signed [ACC_WIDTH:0]   acc_rnd;
  logic signed [RND_W-1:0]     rnd;
  logic signed [RND_W-1:0]     rnd_next;
  logic signed [14:0]          dout_next;
  logic                        sat_next;
  logic                        sat_phase;
  logic                        transfer;

  // Accumulator input path: the first term of a window starts from the
  // bias aligned to the accumulator's fraction point instead of the old sum.
  always_comb begin
    bias_ext = ACC_WIDTH'(bias) <<< SHIFT;
    din_ext  = ACC_WIDTH'(din);
    acc_sum  = ((count == '0) ? bias_ext : acc) + din_ext;
    transfer = din_valid & din_ready;
  end

  // Round half up: add half an LSB one bit wider than acc so the addition
  // cannot wrap, then shift arithmetically to drop the fraction bits.
  always_comb begin
    acc_rnd  = $signed({acc[ACC_WIDTH-1], acc}) + HALF;
    rnd_next = RND_W'(acc_rnd >>> SHIFT);
  end

  // Output conditioning: ReLU clamps to zero without flagging saturation,
  // otherwise values outside the 15-bit signed range are clipped and flagged.
  always_comb begin
    dout_next = 15'(rnd);
    sat_next  = 1'b0;
    if ((RELU != 0) && (rnd < 0)) begin
      dout_next = '0;
    end else if (rnd > MAXV) begin
      dout_next = 15'h3fff;
      sat_next  = 1'b1;
    end else if (rnd < MINV) begin
      dout_next = 15'h4000;
      sat_next  = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and input handshake; din_ready is held low while reset
  // is asserted so no term is taken during a reset cycle.
  always_comb begin
    state_next = state;
    din_ready  = 1'b0;
    case (state)
      ACC: begin
        din_ready = ap_rst_n;
        if (transfer && (count == LAST)) begin
          state_next = SAT;
        end
      end
      SAT: begin
        if (sat_phase) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (dout_ready) begin
          state_next = ACC;
        end
      end
      default: begin
        state_next = ACC;
      end
    endcase
  end

  // Datapath registers: accumulate terms, then spend two cycles in SAT
  // (round, then clip/register) before presenting the result in OUT.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      count      <= '0;
      acc        <= '0;
      rnd        <= '0;
      sat_phase  <= 1'b0;
      dout       <= '0;
      dout_sat   <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (transfer) begin
            acc   <= acc_sum;
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
          end
        end
        SAT: begin
          if (!sat_phase) begin
            rnd       <= rnd_next;
            sat_phase <= 1'b1;
          end else begin
            dout       <= dout_next;
            dout_sat   <= sat_next;
            dout_valid <= 1'b1;
            sat_phase  <= 1'b0;
          end
        end
        OUT: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
          end
        end
        default: begin
          sat_phase <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_mac_acc_27s_15.sv
// Self-checking bench for cnn_mac_acc_27s_15 (NUM_TERMS=4, SHIFT=9).
// Two instances share all inputs: one plain, one with ReLU enabled.
// A window-level model predicts every output each cycle; directed windows
// also pin hand-computed literal results.
module tb_cnn_mac_acc_27s_15;

  localparam int NT = 4;
  localparam int SH = 9;

  typedef logic signed [63:0] w64;

  logic               clk = 1'b0;
  logic               ap_rst_n;
  logic signed [26:0] din;
  logic               din_valid;
  logic signed [14:0] bias;
  logic               dout_ready;

  logic               din_ready;
  logic signed [14:0] dout;
  logic               dout_valid;
  logic               dout_sat;
  logic               r_din_ready;
  logic signed [14:0] r_dout;
  logic               r_dout_valid;
  logic               r_dout_sat;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cnn_mac_acc_27s_15 #(.NUM_TERMS(NT), .SHIFT(SH), .ACC_WIDTH(34), .RELU(0)) dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .bias(bias), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_sat(dout_sat)
  );

  cnn_mac_acc_27s_15 #(.NUM_TERMS(NT), .SHIFT(SH), .ACC_WIDTH(34), .RELU(1)) dut_relu (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .din(din), .din_valid(din_valid),
    .din_ready(r_din_ready), .bias(bias), .dout(r_dout), .dout_valid(r_dout_valid),
    .dout_ready(dout_ready), .dout_sat(r_dout_sat)
  );

  task automatic check_output(input string name, input w64 act, input w64 exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window-level reference model state.
  longint m_sum;
  int     m_terms;
  int     m_lat;
  int     m_windows;
  bit     m_valid;
  bit     m_fresh;
  bit     started;
  longint m_dout, m_sat, m_rdout, m_rsat;

  function automatic void finish_window();
    longint r;
    r = (m_sum + (longint'(1) << (SH - 1))) >>> SH;
    m_sat = 0;
    m_dout = r;
    if (r > 16383) begin m_dout = 16383; m_sat = 1; end
    if (r < -16384) begin m_dout = -16384; m_sat = 1; end
    m_rsat = 0;
    m_rdout = r;
    if (r < 0) m_rdout = 0;
    if (r > 16383) begin m_rdout = 16383; m_rsat = 1; end
  endfunction

  // Model update on every rising edge from the inputs present at that edge.
  initial begin
    started = 0;
    m_windows = 0;
    forever begin
      @(posedge clk);
      started = 1;
      if (!ap_rst_n) begin
        m_terms = 0; m_sum = 0; m_lat = 0; m_valid = 0; m_fresh = 1;
        m_dout = 0; m_sat = 0; m_rdout = 0; m_rsat = 0;
      end else if (m_valid) begin
        if (dout_ready) begin
          m_valid = 0;
          m_windows++;
        end
      end else if (m_lat > 0) begin
        m_lat--;
        if (m_lat == 0) begin
          finish_window();
          m_valid = 1;
          m_fresh = 0;
        end
      end else if (din_valid) begin
        if (m_terms == 0) m_sum = longint'(bias) * (longint'(1) << SH);
        m_sum += longint'(din);
        m_terms++;
        if (m_terms == NT) begin
          m_terms = 0;
          m_lat = 2;
        end
      end
    end
  end

  // Compare both instances against the model mid-cycle.
  initial begin
    bit exp_ready;
    forever begin
      @(negedge clk);
      if (started) begin
        exp_ready = ap_rst_n && !m_valid && (m_lat == 0);
        check_output("din_ready", w64'(din_ready), w64'(exp_ready));
        check_output("relu din_ready", w64'(r_din_ready), w64'(exp_ready));
        check_output("dout_valid", w64'(dout_valid), w64'(m_valid));
        check_output("relu dout_valid", w64'(r_dout_valid), w64'(m_valid));
        if (m_valid || m_fresh) begin
          check_output("dout", w64'(dout), w64'(m_dout));
          check_output("dout_sat", w64'(dout_sat), w64'(m_sat));
          check_output("relu dout", w64'(r_dout), w64'(m_rdout));
          check_output("relu dout_sat", w64'(r_dout_sat), w64'(m_rsat));
        end
      end
    end
  end

  // Offer one term and wait (bounded) for it to be taken.
  task automatic send_term(input int d);
    bit ok;
    ok = 0;
    din = 27'(d);
    din_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (din_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_output("din_ready timeout", 64'sd0, 64'sd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  // One full window with literal expectations for both instances,
  // including the two-edge latency, then an output handshake.
  task automatic apply_stimulus(input string name, input int b, input int d0,
                                input int d1, input int d2, input int d3,
                                input int e_dout, input int e_sat,
                                input int e_rdout, input int e_rsat);
    dout_ready = 1'b0;
    bias = 15'(b);
    send_term(d0);
    send_term(d1);
    send_term(d2);
    send_term(d3);
    check_output({name, " valid edge0"}, w64'(dout_valid), 64'sd0);
    @(posedge clk); #1;
    check_output({name, " valid edge1"}, w64'(dout_valid), 64'sd0);
    @(posedge clk); #1;
    check_output({name, " valid edge2"}, w64'(dout_valid), 64'sd1);
    check_output({name, " dout"}, w64'(dout), w64'(e_dout));
    check_output({name, " sat"}, w64'(dout_sat), w64'(e_sat));
    check_output({name, " relu dout"}, w64'(r_dout), w64'(e_rdout));
    check_output({name, " relu sat"}, w64'(r_dout_sat), w64'(e_rsat));
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    check_output({name, " valid cleared"}, w64'(dout_valid), 64'sd0);
  endtask

  initial begin
    bit done;
    int target;
    ap_rst_n = 1'b0;
    din = '0;
    din_valid = 1'b0;
    bias = '0;
    dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset dout", w64'(dout), 64'sd0);
    check_output("reset sat", w64'(dout_sat), 64'sd0);
    check_output("reset valid", w64'(dout_valid), 64'sd0);
    check_output("reset din_ready", w64'(din_ready), 64'sd0);
    ap_rst_n = 1'b1;
    #1;
    check_output("release din_ready", w64'(din_ready), 64'sd1);

    $display("[TB] directed windows");
    apply_stimulus("basic", 3, 512, 512, 512, 512, 7, 0, 7, 0);
    apply_stimulus("rnd+256", 0, 256, 0, 0, 0, 1, 0, 1, 0);
    apply_stimulus("rnd+255", 0, 255, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus("rnd-257", 0, -257, 0, 0, 0, -1, 0, 0, 0);
    apply_stimulus("rnd-256", 0, -256, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus("sat pos", 0, 67108863, 67108863, 67108863, 67108863, 16383, 1, 16383, 1);
    apply_stimulus("sat neg", 0, -67108864, -67108864, -67108864, -67108864, -16384, 1, 0, 0);
    apply_stimulus("bias min", -16384, 0, 0, 0, 0, -16384, 0, 0, 0);
    apply_stimulus("bias max", 16383, 255, 0, 0, 0, 16383, 0, 16383, 0);
    apply_stimulus("bias max clip", 16383, 256, 0, 0, 0, 16383, 1, 16383, 1);

    $display("[TB] backpressure");
    bias = 15'sd1;
    send_term(512); send_term(512); send_term(512); send_term(512);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("bp first dout", w64'(dout), 64'sd5);
    din = 27'sd512;
    din_valid = 1'b1;
    bias = 15'sd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_output("bp held dout", w64'(dout), 64'sd5);
      check_output("bp held valid", w64'(dout_valid), 64'sd1);
      check_output("bp din_ready", w64'(din_ready), 64'sd0);
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    check_output("bp ready after handshake", w64'(din_ready), 64'sd1);
    repeat (4) begin @(posedge clk); #1; end
    din_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("bp second valid", w64'(dout_valid), 64'sd1);
    check_output("bp second dout", w64'(dout), 64'sd6);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;

    $display("[TB] reset mid-window");
    bias = 15'sd5;
    send_term(1000);
    send_term(1000);
    ap_rst_n = 1'b0;
    @(posedge clk); #1;
    check_output("mid reset dout", w64'(dout), 64'sd0);
    check_output("mid reset valid", w64'(dout_valid), 64'sd0);
    check_output("mid reset din_ready", w64'(din_ready), 64'sd0);
    ap_rst_n = 1'b1;
    #1;
    check_output("mid release din_ready", w64'(din_ready), 64'sd1);
    apply_stimulus("post reset", 0, 512, 512, 512, 512, 4, 0, 4, 0);

    $display("[TB] random gaps, 1000 windows");
    target = m_windows + 1000;
    done = 0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(posedge clk); #1;
      if (m_windows >= target) begin
        done = 1;
        break;
      end
      din_valid = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 0) din = 27'($urandom);
      else din = 27'(int'($urandom_range(4095)) - 2048);
      bias = 15'($urandom);
      dout_ready = ($urandom_range(2) != 0);
    end
    if (!done) check_output("random windows timeout", w64'(m_windows), w64'(target));
    din_valid = 1'b0;
    dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_mac_acc_27s_15.md
CNN_MAC_ACC_27S_15 -- requirements
Module: cnn_mac_acc_27s_15

Interface
REQ-001 SHALL have parameter NUM_TERMS, default 25, products summed per output window (>=1).
REQ-002 SHALL have parameter SHIFT, default 9, fraction bits dropped from accumulator to output (>=1).
REQ-003 SHALL have parameter ACC_WIDTH, default 34, accumulator width (>=27+ceil(log2(NUM_TERMS))+2).
REQ-004 SHALL have parameter RELU, default 0; 1 clamps negative results to zero.
REQ-005 SHALL have port ap_clk, input, 1, sole clock, all state on rising edge.
REQ-006 SHALL have port ap_rst_n, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port din, input, 27, signed product from upstream 11s x 15s multiplier.
REQ-008 SHALL have port din_valid, input, 1, din holds a valid product.
REQ-009 SHALL have port din_ready, output, 1, block accepts din this cycle.
REQ-010 SHALL have port bias, input, 15, signed ap_fixed<15,6>, sampled on first-term accept of each window.
REQ-011 SHALL have port dout, output, 15, signed ap_fixed<15,6> result.
REQ-012 SHALL have port dout_valid, output, 1, dout holds a result.
REQ-013 SHALL have port dout_ready, input, 1, consumer takes dout.
REQ-014 SHALL have port dout_sat, output, 1, qualified by dout_valid; result was clipped.

Function
REQ-015 SHALL implement FSM states ACC, SAT, OUT; leave reset in ACC with term count 0.
REQ-016 SHALL assert din_ready only in ACC; din transfers on din_valid & din_ready at a rising edge.
REQ-017 SHALL, on transfer with count 0, load acc = sext(bias)<<SHIFT + sext(din); otherwise acc = acc + sext(din).
REQ-018 SHALL increment count per transfer; on transfer with count = NUM_TERMS-1 move to SAT, count to 0.
REQ-019 SHALL in SAT compute r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round half up).
REQ-020 SHALL, if RELU=1 and r<0, set r=0 with no saturation flag.
REQ-021 SHALL clip r to [-16384, 16383], set dout_sat=1 iff clipped, register dout, dout_valid=1, move to OUT.
REQ-022 SHALL assert dout_valid on the second rising edge after the last-term transfer edge (2-cycle latency).
REQ-023 SHALL hold dout, dout_sat, dout_valid stable in OUT until dout_ready=1 at a rising edge.
REQ-024 SHALL, on output handshake, clear dout_valid, return to ACC; din_ready=1 the following cycle.
REQ-025 SHALL ignore din_valid outside ACC (no consumption, no state change).
REQ-026 SHALL not overflow acc internally for any input sequence given REQ-003.
REQ-027 SHALL, with NUM_TERMS=1, transfer one term then SAT directly.

Reset
REQ-028 SHALL, while ap_rst_n=0 at a rising edge, set state ACC, count 0, acc 0, dout 0, dout_sat 0, dout_valid 0.
REQ-029 SHALL drive din_ready=0 during reset cycles and 1 in the first cycle after release.
REQ-030 SHALL discard any partial window or pending output when reset is asserted mid-operation.

Verification (NUM_TERMS=4, SHIFT=9, RELU=0 unless stated)
REQ-031 SHALL cover basic sum: bias=3, din=512 x4 -> dout=7, dout_sat=0, dout_valid 2 edges after 4th transfer.
REQ-032 SHALL cover rounding: bias=0, din {256,0,0,0} -> 1; {255,0,0,0} -> 0; {-257,0,0,0} -> -1; {-256,0,0,0} -> 0.
REQ-033 SHALL cover saturation: din=67108863 x4 -> dout=16383, dout_sat=1; din=-67108864 x4 -> dout=-16384, dout_sat=1; RELU=1 same negatives -> dout=0, dout_sat=0.
REQ-034 SHALL cover backpressure: dout_ready=0 for 5 cycles with din_valid=1 -> dout stable, din_ready=0, no terms consumed; dout_ready=1 -> next window bias resampled, correct result.
REQ-035 SHALL cover reset mid-window: 2 of 4 terms accepted, ap_rst_n=0 one cycle -> outputs 0; next 4 terms din=512, bias=0 -> dout=4.
REQ-036 SHALL cover random din_valid/dout_ready gaps over 1000 windows against a reference model, zero mismatches.
